// File: rtl/mult_div_seq.sv
// mult_div_seq: sequential radix-2 multiply / restoring divide unit with
// architectural HI/LO registers and a start/busy/done handshake.
module mult_div_seq #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             wr_hi,
    input  logic             wr_lo,
    input  logic [WIDTH-1:0] wr_data,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned AW = 2 * WIDTH;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_PREP = 3'd1;
    localparam logic [2:0] S_CALC = 3'd2;
    localparam logic [2:0] S_FIX  = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    logic [2:0]       state;
    logic [2:0]       state_next;
    logic [1:0]       op_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             neg_q;
    logic             neg_r;
    logic [AW-1:0]    acc;
    logic [CNT_W-1:0] cnt;

    logic             is_div;
    logic             is_signed;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_abs;
    logic [WIDTH-1:0] b_abs;
    logic             dz;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   rem_sh;
    logic             rem_ge;
    logic [WIDTH-1:0] rem_sub;
    logic [WIDTH-1:0] rem_new;
    logic [AW-1:0]    prod_fix;
    logic [WIDTH-1:0] quot_fix;
    logic [WIDTH-1:0] rem_fix;

    // Operand conditioning and one-bit iteration datapath
    always_comb begin
        is_div    = op_q[1];
        is_signed = ~op_q[0];
        a_neg     = is_signed & a_q[WIDTH-1];
        b_neg     = is_signed & b_q[WIDTH-1];
        a_abs     = a_neg ? -a_q : a_q;
        b_abs     = b_neg ? -b_q : b_q;
        dz        = is_div && (b_q == '0);
        // shift-add: conditional add into upper half, carry kept in the extra bit
        mul_sum   = {1'b0, acc[AW-1:WIDTH]} + (acc[0] ? {1'b0, a_q} : '0);
        // restoring divide: partial remainder after the left shift
        rem_sh    = acc[AW-1:WIDTH-1];
        rem_ge    = rem_sh >= {1'b0, b_q};
        rem_sub   = rem_sh[WIDTH-1:0] - b_q;
        rem_new   = rem_ge ? rem_sub : rem_sh[WIDTH-1:0];
        prod_fix  = neg_q ? -acc : acc;
        quot_fix  = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        rem_fix   = neg_r ? -acc[AW-1:WIDTH] : acc[AW-1:WIDTH];
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: if (start) state_next = S_PREP;
            S_PREP: state_next = dz ? S_DONE : S_CALC;
            S_CALC: if (cnt == CNT_W'(1)) state_next = S_FIX;
            S_FIX:  state_next = S_DONE;
            S_DONE: state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // State register and registered handshake outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_next;
            busy  <= (state_next != S_IDLE);
            done  <= (state_next == S_DONE);
        end
    end

    // Operand capture, iteration, result write-back and HI/LO moves
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            acc      <= '0;
            cnt      <= '0;
            div_zero <= 1'b0;
            hi       <= '0;
            lo       <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        op_q     <= op;
                        a_q      <= src_a;
                        b_q      <= src_b;
                        div_zero <= 1'b0;
                    end else begin
                        if (wr_hi) hi <= wr_data;
                        if (wr_lo) lo <= wr_data;
                    end
                end
                S_PREP: begin
                    neg_q <= a_neg ^ b_neg;
                    neg_r <= a_neg;
                    cnt   <= CNT_W'(WIDTH);
                    a_q   <= a_abs;
                    b_q   <= b_abs;
                    acc   <= is_div ? {{WIDTH{1'b0}}, a_abs} : {{WIDTH{1'b0}}, b_abs};
                    if (dz) div_zero <= 1'b1;
                end
                S_CALC: begin
                    cnt <= cnt - CNT_W'(1);
                    if (is_div) acc <= {rem_new, acc[WIDTH-2:0], rem_ge};
                    else        acc <= {mul_sum, acc[WIDTH-1:1]};
                end
                S_FIX: begin
                    if (is_div) begin
                        hi <= rem_fix;
                        lo <= quot_fix;
                    end else begin
                        hi <= prod_fix[AW-1:WIDTH];
                        lo <= prod_fix[WIDTH-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_seq.sv
// tb_mult_div_seq: directed table, corner sequences and random ops against
// an arithmetic reference model for mult_div_seq.
module tb_mult_div_seq;
    localparam int unsigned W = 32;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic [1:0]    op = 2'd0;
    logic [W-1:0]  src_a = '0;
    logic [W-1:0]  src_b = '0;
    logic          wr_hi = 1'b0;
    logic          wr_lo = 1'b0;
    logic [W-1:0]  wr_data = '0;
    logic          busy;
    logic          done;
    logic          div_zero;
    logic [W-1:0]  hi;
    logic [W-1:0]  lo;

    int n_cmp = 0;
    int n_err = 0;

    logic [W-1:0] mhi = '0;
    logic [W-1:0] mlo = '0;
    logic         mdz = 1'b0;

    typedef struct {
        logic [1:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] ehi;
        logic [W-1:0] elo;
    } vec_t;
    vec_t tbl[10];

    mult_div_seq #(.WIDTH(W), .CNT_W(6)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op),
        .src_a(src_a), .src_b(src_b), .wr_hi(wr_hi), .wr_lo(wr_lo),
        .wr_data(wr_data), .busy(busy), .done(done), .div_zero(div_zero),
        .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: plain 64-bit arithmetic on the architectural operands
    function automatic void model(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [63:0] p;
        logic [63:0] ua;
        logic [63:0] ub;
        longint sa;
        longint sb;
        longint q;
        longint r;
        ua = {32'b0, a};
        ub = {32'b0, b};
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        mdz = 1'b0;
        case (o)
            2'd0: begin p = 64'(sa * sb); mhi = p[63:32]; mlo = p[31:0]; end
            2'd1: begin p = ua * ub;      mhi = p[63:32]; mlo = p[31:0]; end
            default: begin
                if (b == '0) begin
                    mdz = 1'b1;
                end else begin
                    if (o == 2'd2) begin q = sa / sb; r = sa % sb; end
                    else begin q = longint'(ua) / longint'(ub); r = longint'(ua) % longint'(ub); end
                    p = 64'(q); mlo = p[31:0];
                    p = 64'(r); mhi = p[31:0];
                end
            end
        endcase
    endfunction

    task automatic start_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        start = 1'b1; op = o; src_a = a; src_b = b;
        @(negedge clk);
        start = 1'b0; src_a = $urandom; src_b = $urandom;
    endtask

    task automatic wait_done(input int exp_lat, input string name);
        int n;
        n = 0;
        for (int i = 1; i <= 100; i++) begin
            @(negedge clk);
            n = i;
            if (done) break;
        end
        if (!done) n = 999;
        chk({name, " latency"}, 64'(n), 64'(exp_lat));
        chk({name, " busy_at_done"}, 64'(busy), 64'd1);
    endtask

    task automatic run_check(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic [W-1:0] ehi, input logic [W-1:0] elo, input logic edz,
                             input string name);
        start_op(o, a, b);
        wait_done(edz ? 1 : W + 2, name);
        chk({name, " hi"}, 64'(hi), 64'(ehi));
        chk({name, " lo"}, 64'(lo), 64'(elo));
        chk({name, " div_zero"}, 64'(div_zero), 64'(edz));
        @(negedge clk);
        chk({name, " done_drop"}, 64'(done), 64'd0);
        chk({name, " busy_drop"}, 64'(busy), 64'd0);
    endtask

    initial begin
        int cyc;
        logic [1:0]   ro;
        logic [W-1:0] ra;
        logic [W-1:0] rb;

        tbl[0] = '{2'd0, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1};
        tbl[1] = '{2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
        tbl[2] = '{2'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001};
        tbl[3] = '{2'd2, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
        tbl[4] = '{2'd3, 32'h00000007, 32'h00000002, 32'h00000001, 32'h00000003};
        tbl[5] = '{2'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
        tbl[6] = '{2'd2, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
        tbl[7] = '{2'd1, 32'h0000FFFF, 32'h00010001, 32'h00000000, 32'hFFFFFFFF};
        tbl[8] = '{2'd0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
        tbl[9] = '{2'd3, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'hFFFFFFFF};

        // reset state
        #1;
        chk("rst busy", 64'(busy), 64'd0);
        chk("rst done", 64'(done), 64'd0);
        chk("rst div_zero", 64'(div_zero), 64'd0);
        chk("rst hi", 64'(hi), 64'd0);
        chk("rst lo", 64'(lo), 64'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;

        // directed table
        foreach (tbl[i])
            run_check(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].ehi, tbl[i].elo, 1'b0,
                      $sformatf("vec%0d", i));

        // MTHI/MTLO: both together, then individually
        @(negedge clk); wr_hi = 1'b1; wr_lo = 1'b1; wr_data = 32'h11112222;
        @(negedge clk); wr_lo = 1'b0; wr_data = 32'hAAAA5555;
        chk("wr_both hi", 64'(hi), 64'h11112222);
        chk("wr_both lo", 64'(lo), 64'h11112222);
        @(negedge clk); wr_hi = 1'b0; wr_lo = 1'b1; wr_data = 32'h12345678;
        @(negedge clk); wr_lo = 1'b0;
        chk("preload hi", 64'(hi), 64'hAAAA5555);
        chk("preload lo", 64'(lo), 64'h12345678);

        // divide by zero: early done, hi/lo untouched, flag cleared by next start
        run_check(2'd3, 32'd100, 32'd0, 32'hAAAA5555, 32'h12345678, 1'b1, "divu_by_0");
        chk("dz held", 64'(div_zero), 64'd1);
        start_op(2'd1, 32'd2, 32'd3);
        chk("dz cleared", 64'(div_zero), 64'd0);
        wait_done(W + 2, "after_dz");
        chk("after_dz lo", 64'(lo), 64'd6);

        // start and writes in the same IDLE cycle: start wins
        @(negedge clk); @(negedge clk);
        start = 1'b1; op = 2'd1; src_a = 32'd3; src_b = 32'd5;
        wr_hi = 1'b1; wr_lo = 1'b1; wr_data = 32'hDEADBEEF;
        @(negedge clk);
        start = 1'b0; wr_hi = 1'b0; wr_lo = 1'b0;
        chk("start_wins hi", 64'(hi), 64'd0);
        chk("start_wins lo", 64'(lo), 64'd6);
        wait_done(W + 2, "start_wins");
        chk("start_wins res", 64'(lo), 64'd15);

        // start pulses and wr_lo during busy are ignored
        start_op(2'd0, 32'hFFFFFFFD, 32'h00000005);
        cyc = 0;
        for (int i = 0; i < 100; i++) begin
            start = ((cyc + 1) == 5) || ((cyc + 1) == 20);
            op = 2'd3; src_a = 32'd1234; src_b = 32'd3;
            wr_lo = ((cyc + 1) == 25); wr_data = 32'h55555555;
            @(negedge clk);
            cyc++;
            if (done) break;
        end
        start = 1'b0; wr_lo = 1'b0;
        chk("ignore_start latency", 64'(cyc), 64'(W + 2));
        chk("ignore_start hi", 64'(hi), 64'hFFFFFFFF);
        chk("ignore_start lo", 64'(lo), 64'hFFFFFFF1);
        repeat (3) @(negedge clk);
        chk("no_queue busy", 64'(busy), 64'd0);

        // async reset in the middle of a divide
        start_op(2'd2, 32'd100, 32'd7);
        repeat (10) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("midreset busy", 64'(busy), 64'd0);
        chk("midreset done", 64'(done), 64'd0);
        chk("midreset hi", 64'(hi), 64'd0);
        chk("midreset lo", 64'(lo), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        run_check(2'd1, 32'h0000FFFF, 32'h00010001, 32'h0, 32'hFFFFFFFF, 1'b0, "post_reset");
        mhi = 32'h0; mlo = 32'hFFFFFFFF; mdz = 1'b0;

        // random operations against the reference model
        for (int i = 0; i < 40; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            if ($urandom_range(0, 3) == 0) ra = 32'($urandom_range(0, 20)) - 32'd10;
            rb = $urandom;
            if ($urandom_range(0, 3) == 0) rb = 32'($urandom_range(0, 20)) - 32'd10;
            if ($urandom_range(0, 7) == 0) rb = '0;
            model(ro, ra, rb);
            run_check(ro, ra, rb, mhi, mlo, mdz, $sformatf("rand%0d op%0d", i, ro));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
